window_watchdog: RTL and testbench
==================================

WINDOW_WATCHDOG -- requirements
Module: window_watchdog

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the timeout counter and of all threshold inputs.
REQ-002 Parameter RST_PULSE, default 8, SHALL set the wd_rst_o pulse length in clk cycles (legal range 1..255).
REQ-003 Parameter WINDOW_EN, default 1, SHALL enable early-kick detection when 1; when 0, kicks in the closed window count as valid kicks.
REQ-004 Port clk, input, 1 bit: clock, with all state updated on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port en, input, 1 bit: watchdog enable.
REQ-007 Port kick, input, 1 bit: service pulse, sampled every cycle.
REQ-008 Port timeout_i, input, CNT_W bits: cycles allowed between kicks.
REQ-009 Port window_i, input, CNT_W bits: closed-window length, during which a kick is early.
REQ-010 Port warn_i, input, CNT_W bits: early-warning threshold.
REQ-011 Port wd_rst_o, output, 1 bit: registered reset pulse ("bite").
REQ-012 Port warn_o, output, 1 bit: registered early-warning level.
REQ-013 Port early_o, output, 1 bit: sticky flag indicating the last bite was caused by an early kick.
REQ-014 Port state_o, output, 2 bits: current state encoding (IDLE=0, CLOSED=1, OPEN=2, BITE=3).
REQ-015 Port bite_cnt_o, output, 8 bits: saturating count of bites.

Function
REQ-016 The block SHALL implement the states IDLE, CLOSED, OPEN and BITE.
REQ-017 IDLE: counter held at 0; on an edge where en=1, the block SHALL load shadow registers tmo_q/win_q/warn_q from the inputs and enter CLOSED with cnt=0.
REQ-018 Thresholds SHALL be reloaded only on entry to CLOSED; input changes at other times have no effect until the next reload.
REQ-019 Load clamps: timeout_i=0 SHALL be loaded as 1; if window_i >= the clamped timeout, win_q SHALL be loaded as 0 (no closed window).
REQ-020 In CLOSED and OPEN, cnt SHALL increment by 1 per cycle and never wrap, because the exit condition at tmo_q-1 takes precedence.
REQ-021 CLOSED→OPEN SHALL occur on the edge where cnt==win_q-1; with win_q=0, CLOSED SHALL immediately go to OPEN on the next edge, with counting continuing.
REQ-022 A kick in CLOSED with WINDOW_EN=1 SHALL enter BITE on the next edge and set early_o=1.
REQ-023 A valid kick (in OPEN, or in CLOSED with WINDOW_EN=0) SHALL reload the shadows, set cnt=0 and enter CLOSED.
REQ-024 In CLOSED/OPEN, if cnt==tmo_q-1 and kick=0, the block SHALL enter BITE and clear early_o; therefore BITE begins tmo_q edges after entry to CLOSED.
REQ-025 A kick on the same cycle as cnt==tmo_q-1 in OPEN SHALL win, with no bite.
REQ-026 BITE: wd_rst_o SHALL be 1 for exactly RST_PULSE cycles; kicks in BITE SHALL be ignored; bite_cnt_o SHALL increment once on entry and saturate at 255.
REQ-027 On BITE exit, the block SHALL enter CLOSED with reloaded shadows if en=1, else IDLE.
REQ-028 Deasserting en in CLOSED/OPEN SHALL enter IDLE on the next edge, with cnt=0 and warn_o=0; deasserting en in BITE SHALL NOT shorten the pulse.
REQ-029 warn_o SHALL be 1 when the state is CLOSED or OPEN and cnt >= warn_q, and 0 otherwise; warn_q=0 SHALL give continuous warning while counting.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-031 While rst=1, the block SHALL hold state=IDLE, cnt=0, pulse counter=0, shadow registers=0, wd_rst_o=0, warn_o=0, early_o=0 and bite_cnt_o=0.
REQ-032 Assertion of rst mid-BITE SHALL terminate the pulse immediately; after rst is released, the block SHALL resume from IDLE.

Structure
REQ-033 Package wdt_pkg SHALL hold the state encoding constants and the default values of CNT_W and RST_PULSE.
REQ-034 Sub-module wdt_pulse_stretch SHALL generate the RST_PULSE-cycle wd_rst_o from a one-cycle start strobe; all other logic SHALL reside in window_watchdog.

Verification (CNT_W=16, RST_PULSE=8, WINDOW_EN=1 unless noted)
REQ-035 Scenario: timeout_i=10, window_i=0, en=1 sampled at edge 0, no kick → wd_rst_o=1 on edges 10..17; bite_cnt_o=1; early_o=0; state_o back to 1 at edge 18.
REQ-036 Scenario: timeout_i=10, window_i=4, kick at cnt=6 every period for 50 cycles → wd_rst_o never asserted; state_o cycles 1→2→1.
REQ-037 Scenario: timeout_i=10, window_i=4, kick at cnt=2 → BITE on the next edge; early_o=1; an 8-cycle pulse.
REQ-038 Scenario: timeout_i=10, window_i=4, kick at cnt=9 → no bite; cnt=0; state CLOSED.
REQ-039 Scenario: warn_i=7 → warn_o rises at cnt=7, falls on kick or on entry to BITE; timeout_i=0 → bite 1 edge after CLOSED entry; window_i=12 with timeout_i=10 → window disabled.
REQ-040 Scenario: en dropped at BITE cycle 3 → pulse lasts 8 cycles, then IDLE; rst asserted at BITE cycle 3 → wd_rst_o=0 immediately; 300 forced bites → bite_cnt_o=255.

Source files
------------

// File: rtl/wdt_pkg.sv
// wdt_pkg: shared definitions for the window watchdog.
//   wdt_state_e        - FSM state encoding, also exported on state_o
//   WDT_CNT_W_DEF      - default width of the timeout counter and thresholds
//   WDT_RST_PULSE_DEF  - default bite pulse length in clk cycles
package wdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLOSED = 2'd1,
    ST_OPEN   = 2'd2,
    ST_BITE   = 2'd3
  } wdt_state_e;

  localparam int unsigned WDT_CNT_W_DEF     = 16;
  localparam int unsigned WDT_RST_PULSE_DEF = 8;

endpackage

// File: rtl/wdt_pulse_stretch.sv
// wdt_pulse_stretch: turns a one-cycle start strobe into a registered
// RST_PULSE-cycle pulse.
//   clk, rst  - clock, asynchronous active-high reset
//   start_i   - one-cycle strobe; pulse_o rises on the same edge
//   pulse_o   - registered pulse, high for exactly RST_PULSE cycles
//   done_o    - high during the last pulse cycle (from registers only)
module wdt_pulse_stretch
  import wdt_pkg::*;
#(
  parameter int unsigned RST_PULSE = WDT_RST_PULSE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic pulse_o,
  output logic done_o
);

  // Remaining cycles after the current one; pulse ends when it reaches zero.
  localparam logic [7:0] LOAD = 8'(RST_PULSE - 1);

  logic [7:0] left_q, left_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    left_d  = left_q;
    pulse_d = pulse_q;
    if (start_i) begin
      pulse_d = 1'b1;
      left_d  = LOAD;
    end else if (pulse_q) begin
      if (left_q == '0) begin
        pulse_d = 1'b0;
      end else begin
        left_d = left_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign done_o  = pulse_q && (left_q == '0);

endmodule

// File: rtl/window_watchdog.sv
// window_watchdog: windowed watchdog timer.
//   clk, rst    - clock, asynchronous active-high reset
//   en          - watchdog enable
//   kick        - service pulse, sampled every cycle
//   timeout_i   - cycles allowed between kicks (0 treated as 1)
//   window_i    - closed-window length; a kick inside it is early
//   warn_i      - early-warning threshold on the counter
//   wd_rst_o    - registered bite pulse, RST_PULSE cycles long
//   warn_o      - registered warning level
//   early_o     - sticky: last bite was caused by an early kick
//   state_o     - current state (IDLE=0, CLOSED=1, OPEN=2, BITE=3)
//   bite_cnt_o  - saturating bite counter
module window_watchdog
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W     = WDT_CNT_W_DEF,
  parameter int unsigned RST_PULSE = WDT_RST_PULSE_DEF,
  parameter bit          WINDOW_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic [CNT_W-1:0] window_i,
  input  logic [CNT_W-1:0] warn_i,
  output logic             wd_rst_o,
  output logic             warn_o,
  output logic             early_o,
  output logic [1:0]       state_o,
  output logic [7:0]       bite_cnt_o
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d, win_q, win_d, warn_q, warn_d;
  logic [CNT_W-1:0] tmo_ld, win_ld;
  logic             warn_lvl_q, warn_lvl_d;
  logic             early_q, early_d;
  logic [7:0]       bite_cnt_q, bite_cnt_d;
  logic             reload, at_tmo, at_win;
  logic             bite_start, pulse_done;

  // Clamped threshold values captured on every entry to CLOSED.
  always_comb begin
    tmo_ld = (timeout_i == '0) ? CNT_W'(1) : timeout_i;
    win_ld = (window_i >= tmo_ld) ? '0 : window_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    early_d = early_q;
    reload  = 1'b0;
    at_tmo  = (cnt_q == tmo_q - CNT_W'(1));
    at_win  = (win_q == '0) || (cnt_q == win_q - CNT_W'(1));
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en) begin
          reload  = 1'b1;
          state_d = ST_CLOSED;
        end
      end
      ST_CLOSED, ST_OPEN: begin
        // Priority: disable, kick, timeout, then count. Timeout is checked
        // before the increment, so the counter can never wrap.
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (kick && WINDOW_EN && (state_q == ST_CLOSED)) begin
          state_d = ST_BITE;
          cnt_d   = '0;
          early_d = 1'b1;
        end else if (kick) begin
          reload  = 1'b1;
          state_d = ST_CLOSED;
          cnt_d   = '0;
        end else if (at_tmo) begin
          state_d = ST_BITE;
          cnt_d   = '0;
          early_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_CLOSED && at_win) begin
            state_d = ST_OPEN;
          end
        end
      end
      ST_BITE: begin
        cnt_d = '0;
        if (pulse_done) begin
          if (en) begin
            reload  = 1'b1;
            state_d = ST_CLOSED;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_d      = reload ? tmo_ld : tmo_q;
    win_d      = reload ? win_ld : win_q;
    warn_d     = reload ? warn_i : warn_q;
    bite_start = (state_q != ST_BITE) && (state_d == ST_BITE);
    bite_cnt_d = (bite_start && (bite_cnt_q != 8'hFF)) ? bite_cnt_q + 8'd1 : bite_cnt_q;
    // Computed from next-state values so warn_o stays a pure register.
    warn_lvl_d = ((state_d == ST_CLOSED) || (state_d == ST_OPEN)) && (cnt_d >= warn_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      win_q      <= '0;
      warn_q     <= '0;
      warn_lvl_q <= 1'b0;
      early_q    <= 1'b0;
      bite_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      win_q      <= win_d;
      warn_q     <= warn_d;
      warn_lvl_q <= warn_lvl_d;
      early_q    <= early_d;
      bite_cnt_q <= bite_cnt_d;
    end
  end

  wdt_pulse_stretch #(
    .RST_PULSE(RST_PULSE)
  ) u_pulse (
    .clk    (clk),
    .rst    (rst),
    .start_i(bite_start),
    .pulse_o(wd_rst_o),
    .done_o (pulse_done)
  );

  assign warn_o     = warn_lvl_q;
  assign early_o    = early_q;
  assign state_o    = state_q;
  assign bite_cnt_o = bite_cnt_q;

endmodule

// File: tb/tb_window_watchdog.sv
// tb_window_watchdog: scoreboard bench for window_watchdog (defaults:
// CNT_W=16, RST_PULSE=8, WINDOW_EN=1). Stimulus pushes expected output
// snapshots tagged with the edge they apply to; a monitor pops and compares.
module tb_window_watchdog;

  localparam int M_WD = 1, M_WR = 2, M_ER = 4, M_ST = 8, M_BC = 16, M_ALL = 31;

  logic        clk, rst, en, kick;
  logic [15:0] timeout_i, window_i, warn_i;
  logic        wd_rst_o, warn_o, early_o;
  logic [1:0]  state_o;
  logic [7:0]  bite_cnt_o;

  window_watchdog #(
    .CNT_W(16),
    .RST_PULSE(8),
    .WINDOW_EN(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .kick      (kick),
    .timeout_i (timeout_i),
    .window_i  (window_i),
    .warn_i    (warn_i),
    .wd_rst_o  (wd_rst_o),
    .warn_o    (warn_o),
    .early_o   (early_o),
    .state_o   (state_o),
    .bite_cnt_o(bite_cnt_o)
  );

  typedef struct {
    int    cyc;
    string nm;
    int    m;
    int    wd, wr, er, st, bc;
  } exp_t;

  exp_t sb_q[$];
  int   edge_n = 0;
  int   tests  = 0;
  int   fails  = 0;
  event sample_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    edge_n = edge_n + 1;
    -> sample_ev;
  end

  always begin
    @(sample_ev);
    while (sb_q.size() != 0 && sb_q[0].cyc <= edge_n) begin
      exp_t       e;
      bit         ok;
      logic       x_wd, x_wr, x_er;
      logic [1:0] x_st;
      logic [7:0] x_bc;
      e    = sb_q.pop_front();
      ok   = 1'b1;
      x_wd = e.wd[0];
      x_wr = e.wr[0];
      x_er = e.er[0];
      x_st = e.st[1:0];
      x_bc = e.bc[7:0];
      tests = tests + 1;
      if ((e.m & M_WD) != 0 && wd_rst_o !== x_wd) begin
        ok = 1'b0;
        $display("FAIL %s @edge %0d: wd_rst_o=%b exp %b", e.nm, edge_n, wd_rst_o, x_wd);
      end
      if ((e.m & M_WR) != 0 && warn_o !== x_wr) begin
        ok = 1'b0;
        $display("FAIL %s @edge %0d: warn_o=%b exp %b", e.nm, edge_n, warn_o, x_wr);
      end
      if ((e.m & M_ER) != 0 && early_o !== x_er) begin
        ok = 1'b0;
        $display("FAIL %s @edge %0d: early_o=%b exp %b", e.nm, edge_n, early_o, x_er);
      end
      if ((e.m & M_ST) != 0 && state_o !== x_st) begin
        ok = 1'b0;
        $display("FAIL %s @edge %0d: state_o=%0d exp %0d", e.nm, edge_n, state_o, x_st);
      end
      if ((e.m & M_BC) != 0 && bite_cnt_o !== x_bc) begin
        ok = 1'b0;
        $display("FAIL %s @edge %0d: bite_cnt_o=%0d exp %0d", e.nm, edge_n, bite_cnt_o, x_bc);
      end
      if (!ok) begin
        fails = fails + 1;
      end
    end
  end

  task automatic push(int cyc, string nm, int m, int wd, int wr, int er, int st, int bc);
    exp_t e;
    int   i;
    e.cyc = cyc; e.nm = nm; e.m = m;
    e.wd = wd; e.wr = wr; e.er = er; e.st = st; e.bc = bc;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= cyc) i++;
    sb_q.insert(i, e);
  endtask

  // Expectation for edge e of a scenario; edge 0 is the first edge after base.
  task automatic ex(int b, int e, string nm, int m, int wd, int wr, int er, int st, int bc);
    push(b + e + 1, nm, m, wd, wr, er, st, bc);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; en = 1'b0; kick = 1'b0;
    timeout_i = '0; window_i = '0; warn_i = '0;
    step(3);
    push(edge_n + 1, "reset_hold", M_ALL, 0, 0, 0, 0, 0);
    step(1);
    rst = 1'b0;
    push(edge_n + 1, "idle_after_reset", M_ALL, 0, 0, 0, 0, 0);
    step(2);

    // S1: no kick, timeout 10, no window
    timeout_i = 16'd10; window_i = 16'd0; warn_i = 16'hFFFF;
    base = edge_n; en = 1'b1;
    ex(base, 0,  "s1_closed",     M_ALL,       0, 0, 0, 1, 0);
    ex(base, 1,  "s1_open",       M_WD | M_ST, 0, 0, 0, 2, 0);
    ex(base, 9,  "s1_pre_bite",   M_WD | M_ST, 0, 0, 0, 2, 0);
    ex(base, 10, "s1_bite_start", M_ALL,       1, 0, 0, 3, 1);
    ex(base, 17, "s1_bite_end",   M_WD | M_ST, 1, 0, 0, 3, 1);
    ex(base, 18, "s1_reclosed",   M_ALL,       0, 0, 0, 1, 1);
    step(19); en = 1'b0;
    ex(base, 19, "s1_idle",       M_ALL,       0, 0, 0, 0, 1);
    step(2);

    // S2: window 4, kick at cnt=6 each period
    window_i = 16'd4;
    base = edge_n; en = 1'b1;
    for (int p = 0; p < 7; p++) begin
      ex(base, 7 * p,     "s2_closed", M_WD | M_ST, 0, 0, 0, 1, 1);
      ex(base, 7 * p + 4, "s2_open",   M_WD | M_ST, 0, 0, 0, 2, 1);
      step(1); kick = 1'b0;
      step(6); kick = 1'b1;
    end
    ex(base, 49, "s2_final_closed", M_ALL, 0, 0, 0, 1, 1);
    step(1); kick = 1'b0; en = 1'b0;
    ex(base, 50, "s2_idle", M_ALL, 0, 0, 0, 0, 1);
    step(2);

    // S3: early kick at cnt=2, kicks during BITE ignored
    base = edge_n; en = 1'b1;
    ex(base, 2,  "s3_closed_cnt2",  M_WD | M_ST,        0, 0, 0, 1, 1);
    ex(base, 3,  "s3_early_bite",   M_ALL,              1, 0, 1, 3, 2);
    ex(base, 10, "s3_pulse_last",   M_WD | M_ST | M_BC, 1, 0, 1, 3, 2);
    ex(base, 11, "s3_reclosed",     M_ALL,              0, 0, 1, 1, 2);
    ex(base, 12, "s3_idle",         M_ALL,              0, 0, 1, 0, 2);
    step(3); kick = 1'b1;
    step(3); kick = 1'b0;
    step(6); en = 1'b0;
    step(2);

    // S4: warn at 7, kick at cnt=9 wins over timeout
    warn_i = 16'd7;
    base = edge_n; en = 1'b1;
    ex(base, 6,  "s4_below_warn",   M_WR | M_ST,        0, 0, 1, 2, 2);
    ex(base, 7,  "s4_warn_rise",    M_WD | M_WR | M_ST, 0, 1, 1, 2, 2);
    ex(base, 9,  "s4_warn_hold",    M_WD | M_WR | M_ST, 0, 1, 1, 2, 2);
    ex(base, 10, "s4_late_kick_ok", M_ALL,              0, 0, 1, 1, 2);
    ex(base, 11, "s4_idle",         M_ALL,              0, 0, 1, 0, 2);
    step(10); kick = 1'b1;
    step(1);  kick = 1'b0; en = 1'b0;
    step(2);

    // S5: warn falls on bite; en dropped at BITE cycle 3
    window_i = 16'd0;
    base = edge_n; en = 1'b1;
    ex(base, 9,  "s5_warn_pre_bite", M_WR | M_ST, 0, 1, 0, 2, 2);
    ex(base, 10, "s5_bite_warn_off", M_ALL,       1, 0, 0, 3, 3);
    ex(base, 17, "s5_pulse_full",    M_WD | M_ST, 1, 0, 0, 3, 3);
    ex(base, 18, "s5_idle_after",    M_ALL,       0, 0, 0, 0, 3);
    step(13); en = 1'b0;
    step(8);

    // S6: timeout 0 -> 1, warn 0 -> warning immediately
    timeout_i = 16'd0; warn_i = 16'd0;
    base = edge_n; en = 1'b1;
    ex(base, 0, "s6_warn_zero",  M_ALL,       0, 1, 0, 1, 3);
    ex(base, 1, "s6_tmo0_bite",  M_ALL,       1, 0, 0, 3, 4);
    ex(base, 8, "s6_pulse_last", M_WD | M_ST, 1, 0, 0, 3, 4);
    ex(base, 9, "s6_idle",       M_ALL,       0, 0, 0, 0, 4);
    step(2); en = 1'b0;
    step(10);

    // S7: window >= timeout disables the closed window
    timeout_i = 16'd10; window_i = 16'd12; warn_i = 16'hFFFF;
    base = edge_n; en = 1'b1;
    ex(base, 1, "s7_no_window", M_WD | M_ST, 0, 0, 0, 2, 4);
    ex(base, 2, "s7_kick_ok",   M_ALL,       0, 0, 0, 1, 4);
    ex(base, 3, "s7_idle",      M_ALL,       0, 0, 0, 0, 4);
    step(2); kick = 1'b1;
    step(1); kick = 1'b0; en = 1'b0;
    step(2);

    // S8: async reset in the middle of a bite
    timeout_i = 16'd2; window_i = 16'd0;
    base = edge_n; en = 1'b1;
    ex(base, 2, "s8_bite",    M_ALL,       1, 0, 0, 3, 5);
    ex(base, 5, "s8_bite_c3", M_WD | M_ST, 1, 0, 0, 3, 5);
    step(6);
    rst = 1'b1;
    #1;
    push(edge_n, "s8_async_rst", M_ALL, 0, 0, 0, 0, 0);
    -> sample_ev;
    timeout_i = 16'd0;
    push(edge_n + 1, "s8_rst_hold", M_ALL, 0, 0, 0, 0, 0);
    step(1);
    rst = 1'b0;

    // S9: repeated bites saturate the bite counter (9 edges per bite)
    base = edge_n;
    ex(base, 0,    "s9_resume_closed", M_ALL,              0, 0, 0, 1, 0);
    ex(base, 1,    "s9_first",         M_WD | M_ST | M_BC, 1, 0, 0, 3, 1);
    ex(base, 2286, "s9_bc254",         M_ALL,              0, 0, 0, 1, 254);
    ex(base, 2287, "s9_bc255",         M_ALL,              1, 0, 0, 3, 255);
    ex(base, 2700, "s9_after300",      M_ALL,              0, 0, 0, 1, 255);
    ex(base, 2701, "s9_saturated",     M_ALL,              1, 0, 0, 3, 255);
    ex(base, 2709, "s9_idle",          M_WD | M_ST | M_BC, 0, 0, 0, 0, 255);
    step(2702); en = 1'b0;
    step(10);

    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.nm, e.cyc, edge_n);
    end

    if (fails != 0) begin
      $display("FAIL: %0d of %0d checks failed", fails, tests);
    end else begin
      $display("PASS: all %0d checks passed", tests);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
